// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Bundle between the 5-stage pipeline datapath and its central
//                sequencer. Carries the hazard-detection inputs observed in
//                ID/EX/MEM, the stage-register enable/flush/bubble controls,
//                and the halt/error/stall-count status.
//  Modports    : master - the sequencer (reads hazard info, drives controls)
//                slave  - the datapath  (drives hazard info, reads controls)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard information from the datapath
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_halt;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    // Stage-register controls
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic             exmem_en;
    logic             memwb_en;

    // Status
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  id_rs, id_rt, id_uses_rt, id_halt, ex_is_load, ex_rd,
               branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, memwb_en, halted, mem_err, stall_cnt
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, id_halt, ex_is_load, ex_rd,
               branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
               exmem_en, memwb_en, halted, mem_err, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Central sequencer for the 5-stage MIPS32 pipeline. Resolves
//                load-use stalls, taken-branch flushes, data-memory freezes
//                (with timeout) and HLT drain/halt, and keeps a saturating
//                stall-cycle counter.
//  Ports       : clk  - pipeline clock (posedge)
//                rst  - synchronous active-high reset
//                bus  - pipe_ctrl_if.master: hazard inputs, stage controls,
//                       halted / mem_err / stall_cnt status
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  wire             clk,
    input  wire             rst,
    pipe_ctrl_if.master     bus
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    state_t              ret_q, ret_d;      // state to resume after a freeze
    state_t              eff_state;         // state whose rules apply this cycle
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
    logic load_use, frozen;

    assign load_use = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

    // A new freeze can only start from a state that advances the pipeline.
    assign frozen = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                    bus.mem_req && !bus.mem_ready;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        mem_err_d   = mem_err_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;

        // The cycle in which memory finally answers is processed under the
        // rules of the state that was interrupted.
        eff_state = state_q;
        if ((state_q == ST_MEM_WAIT) && bus.mem_ready) begin
            eff_state = ret_q;
        end

        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if ((state_q == ST_MEM_WAIT) && !bus.mem_ready) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            if (wait_cnt_q == WAIT_LAST) begin
                mem_err_d = 1'b1;
                state_d   = ST_HALTED;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else if (frozen) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            ret_d      = state_q;
            wait_cnt_d = '0;
            state_d    = ST_MEM_WAIT;
        end else begin
            case (eff_state)
                ST_RUN: begin
                    state_d = ST_RUN;
                    if (bus.branch_taken) begin
                        // PC takes the target; the two younger slots are squashed.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (bus.id_halt) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                        state_d     = ST_DRAIN;
                    end
                end
                default: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
                    state_d = ST_HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            mem_err_q   <= mem_err_d;
            if (!pc_en && (state_q != ST_HALTED) && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    // Status reads as cleared for the whole reset cycle, not just after it.
    assign bus.halted      = (state_q == ST_HALTED) && !rst;
    assign bus.mem_err     = mem_err_q && !rst;
    assign bus.stall_cnt   = rst ? '0 : stall_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the 5-stage MIPS32 pipeline. Drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB register enables, flush and bubble controls.
- Resolves three hazard classes and one terminal condition:
  - load-use hazards (1-cycle stall plus bubble)
  - taken branches resolved in EX (flush of IF/ID and ID/EX)
  - multi-cycle data-memory waits (full freeze, with timeout)
  - HLT (drain of older instructions, then a permanent halt)
- Keeps a saturating stall-cycle counter for performance visibility.

Parameters:
- DRAIN_CYCLES, 3, cycles needed after HLT leaves ID to retire the older instructions in EX/MEM/WB.
- MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles without mem_ready before the error halt.
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- id_halt  in  1  the ID instruction is HLT.
- ex_is_load  in  1  the EX instruction is LW.
- ex_rd  in  5  destination register of the EX instruction.
- branch_taken  in  1  EX branch condition resolved taken.
- mem_req  in  1  the MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  load NOP into ID/EX instead of ID outputs.
- exmem_en  out  1  EX/MEM load enable.
- memwb_en  out  1  MEM/WB load enable.
- halted  out  1  pipeline permanently stopped.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Control outputs are combinational from the registered state plus the current inputs. State, counters and flags are registered.
- While rst=1:
  - all *_en = 0, ifid_flush = 1, idex_bubble = 1
  - halted = 0, mem_err = 0, stall_cnt = 0
  - next state RUN, wait and drain counters cleared
  - reset overrides any state, including HALTED, MEM_WAIT and DRAIN.
- States: RUN, MEM_WAIT, DRAIN, HALTED. Default output in RUN with no hazard: all *_en = 1, ifid_flush = 0, idex_bubble = 0.
- Priority, highest first: memory freeze > branch_taken > id_halt > load-use.
- Memory freeze (RUN or DRAIN, mem_req=1 and mem_ready=0):
  - all *_en = 0, no flush, no bubble
  - return state is saved; go to MEM_WAIT.
- MEM_WAIT:
  - all *_en = 0 and the wait counter increments.
  - mem_ready=1: this cycle is evaluated with the saved state's rules (branch, load-use and drain all apply); return to the saved state.
  - Counter reaches MEM_TIMEOUT without ready: mem_err := 1, go to HALTED.
  - Hazard inputs are stable during the freeze because all stage registers hold.
- branch_taken (RUN, not frozen):
  - pc_en = 1 (loads the target), ifid_flush = 1, idex_bubble = 1, exmem_en = memwb_en = 1
  - squashes a simultaneous id_halt and load-use.
- id_halt (RUN, no branch, not frozen):
  - pc_en = 0, ifid_en = 0, idex_en = 1 (HLT advances)
  - go to DRAIN with the drain counter at 0.
- Load-use hazard, when ex_is_load=1, ex_rd≠0 and (ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt)):
  - pc_en = 0, ifid_en = 0, idex_bubble = 1, exmem_en = memwb_en = 1
  - exactly 1 cycle; re-evaluated the next cycle.
- DRAIN:
  - pc_en = 0, ifid_en = 0, idex_bubble = 1, exmem_en = memwb_en = 1
  - the drain counter increments only on non-frozen cycles
  - after DRAIN_CYCLES advancing cycles, go to HALTED.
- HALTED: all *_en = 0, halted = 1. Exits only on rst.
- stall_cnt:
  - increments each non-reset cycle with pc_en=0 in RUN, MEM_WAIT or DRAIN
  - saturates at 2^CNT_W−1
  - frozen in HALTED.

Test Plan:
- Reset mid-MEM_WAIT: mem_req=1, mem_ready=0 for 5 cycles, then rst=1 for 1 cycle → all en=0 during reset; the next cycle is RUN with all en=1 and stall_cnt=0.
- Load-use: ex_is_load=1, ex_rd=8, id_rs=8 → 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1. Repeat with ex_rd=0 → no stall. Repeat with id_rt=8, id_uses_rt=0 → no stall.
- Branch and load-use together: branch_taken=1 with a load-use match → pc_en=1, ifid_flush=1, idex_bubble=1; stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high → 3 cycles all en=0, then a normal cycle; stall_cnt += 3. With MEM_TIMEOUT=4 and ready never asserted → mem_err=1 and halted=1 after 4 MEM_WAIT cycles.
- HLT drain: id_halt=1 → DRAIN with exmem_en=1 for 3 cycles, then halted=1 and all en=0. Repeat with a 2-cycle memory stall mid-drain → halted is asserted 2 cycles later.
- HLT vs branch: id_halt=1 and branch_taken=1 in the same cycle → flush, stay in RUN, halted stays 0.
